// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter and its read-response router.
package dmem_arb_pkg;

    localparam int unsigned DMEM_AW = 15;
    localparam int unsigned DMEM_DW = 16;
    localparam int unsigned BURST_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_AUX, ST_LOCK} arb_st_t;
    typedef enum logic {OWN_CPU, OWN_AUX} own_t;

endpackage

// File: rtl/dmem_rsp_route.sv
// Read-response tracker: remembers who issued the granted read and steers mem_rdata back to it.
module dmem_rsp_route
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DW = DMEM_DW
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic          rd_fire,
    input  own_t          rd_own_nxt,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata
);

    logic rd_pend;
    own_t rd_own;

    // Async clear drops any read that was in flight when reset hit.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_own  <= OWN_CPU;
        end else begin
            rd_pend <= rd_fire;
            if (rd_fire) begin
                rd_own <= rd_own_nxt;
            end
        end
    end

    always_comb begin
        cpu_rvalid = rd_pend && (rd_own == OWN_CPU);
        aux_rvalid = rd_pend && (rd_own == OWN_AUX);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        aux_rdata  = aux_rvalid ? mem_rdata : '0;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU / aux arbiter for the single data-memory port, with bounded aux burst lock.
// Define DMEM_ARB_RR_EN for round-robin contention; default build is fixed CPU priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW        = DMEM_AW,
    parameter int unsigned DW        = DMEM_DW,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic          clk50m,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          aux_req,
    input  logic          aux_lock,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    arb_st_t            st;
    logic [BURST_W-1:0] burst_cnt;
    logic               lock_ok;
    logic               cpu_wins;

`ifdef DMEM_ARB_RR_EN
    own_t last_own;

    // Owner of the most recent grant; idles keep it so alternation survives gaps.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            last_own <= OWN_AUX;
        end else if (cpu_gnt) begin
            last_own <= OWN_CPU;
        end else if (aux_gnt) begin
            last_own <= OWN_AUX;
        end
    end

    assign cpu_wins = (last_own == OWN_AUX);
`else
    assign cpu_wins = 1'b1;
`endif

    // Grant: unexpired lock first, then single requester, then contention policy.
    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        lock_ok = (st == ST_LOCK) && aux_req && aux_lock && (burst_cnt < BURST_MAX);
        if (!rst) begin
            if (lock_ok) begin
                aux_gnt = 1'b1;
            end else if (cpu_req && aux_req) begin
                cpu_gnt = cpu_wins;
                aux_gnt = !cpu_wins;
            end else begin
                cpu_gnt = cpu_req;
                aux_gnt = aux_req;
            end
        end
    end

    always_comb begin
        mem_addr  = aux_gnt ? aux_addr  : cpu_addr;
        mem_wdata = aux_gnt ? aux_wdata : cpu_wdata;
        mem_we    = (cpu_gnt && cpu_we) || (aux_gnt && aux_we);
    end

    // Burst counter saturates at MAX_BURST while aux keeps a locked grant uncontested.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            st        <= ST_IDLE;
            burst_cnt <= '0;
        end else if (aux_gnt && aux_lock) begin
            st <= ST_LOCK;
            if (st != ST_LOCK) begin
                burst_cnt <= BURST_W'(1);
            end else if (burst_cnt < BURST_MAX) begin
                burst_cnt <= burst_cnt + BURST_W'(1);
            end
        end else if (aux_gnt) begin
            st        <= ST_AUX;
            burst_cnt <= '0;
        end else if (cpu_gnt) begin
            st        <= ST_CPU;
            burst_cnt <= '0;
        end else begin
            st        <= ST_IDLE;
            burst_cnt <= '0;
        end
    end

    dmem_rsp_route #(.DW(DW)) u_rsp (
        .clk50m     (clk50m),
        .rst        (rst),
        .rd_fire    ((cpu_gnt && !cpu_we) || (aux_gnt && !aux_we)),
        .rd_own_nxt (aux_gnt ? OWN_AUX : OWN_CPU),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .aux_rvalid (aux_rvalid),
        .aux_rdata  (aux_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (MAX_BURST=4); contention expectations follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;

    logic          clk50m = 1'b0;
    logic          rst    = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          aux_req = 1'b0, aux_lock = 1'b0, aux_we = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid, mem_we;
    logic [DW-1:0] cpu_rdata, aux_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk50m(clk50m), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_lock(aux_lock), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk50m = ~clk50m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk50m);
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic ar, input logic al, input logic aw, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        aux_req = ar; aux_lock = al; aux_we = aw; aux_addr = aa; aux_wdata = ad;
    endtask

    task automatic idle();
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        #1;
    endtask

    initial begin
        // Reset with both masters requesting
        drive(1, 1, 15'h0100, 16'h5555, 1, 0, 1, 15'h0200, 16'h6666);
        mem_rdata = 16'h9999;
        next_cycle(); #1;
        check("rst_cpu_gnt", 32'(cpu_gnt), 0);
        check("rst_aux_gnt", 32'(aux_gnt), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        check("rst_aux_rvalid", 32'(aux_rvalid), 0);
        check("rst_aux_rdata", 32'(aux_rdata), 0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("first_contend_cpu", 32'(cpu_gnt), 1);
        check("first_contend_aux", 32'(aux_gnt), 0);
        check("first_contend_we", 32'(mem_we), 1);

        // CPU read with aux idle
        next_cycle();
        drive(1, 0, 15'h0010, '0, 0, 0, 0, '0, '0);
        #1;
        check("rd_cpu_gnt", 32'(cpu_gnt), 1);
        check("rd_mem_addr", 32'(mem_addr), 32'h0010);
        check("rd_mem_we", 32'(mem_we), 0);
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        mem_rdata = 16'hBEEF;
        #1;
        check("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
        check("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
        check("rd_aux_rvalid", 32'(aux_rvalid), 0);
        check("rd_aux_rdata", 32'(aux_rdata), 0);

`ifdef DMEM_ARB_RR_EN
        // Continuous contending reads; last owner was CPU, so aux goes first
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1, 0, 15'h0300, '0, 1, 0, 0, 15'h0400, '0);
            mem_rdata = 16'h1000 + 16'(i);
            #1;
            check($sformatf("rr_aux_gnt%0d", i), 32'(aux_gnt), 32'((i % 2) == 0));
            check($sformatf("rr_cpu_gnt%0d", i), 32'(cpu_gnt), 32'((i % 2) == 1));
            if (i > 0) begin
                check($sformatf("rr_cpu_rv%0d", i), 32'(cpu_rvalid), 32'((i % 2) == 0));
                check($sformatf("rr_aux_rv%0d", i), 32'(aux_rvalid), 32'((i % 2) == 1));
                check($sformatf("rr_rdata%0d", i), 32'(cpu_rdata | aux_rdata), 32'h1000 + 32'(i));
            end
        end
        next_cycle();
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        mem_rdata = 16'h1004;
        #1;
        check("rr_tail_cpu_rv", 32'(cpu_rvalid), 1);
        check("rr_tail_cpu_rdata", 32'(cpu_rdata), 32'h1004);
`else
        // Contending writes: CPU holds the port until it drops its request
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1, 1, 15'h7000, 16'h1234, 1, 0, 1, 15'h0001, 16'hAAAA);
            #1;
            check($sformatf("fx_cpu_gnt%0d", i), 32'(cpu_gnt), 1);
            check($sformatf("fx_aux_gnt%0d", i), 32'(aux_gnt), 0);
            check($sformatf("fx_mem_addr%0d", i), 32'(mem_addr), 32'h7000);
            check($sformatf("fx_mem_wdata%0d", i), 32'(mem_wdata), 32'h1234);
        end
        next_cycle();
        cpu_req = 1'b0;
        #1;
        check("fx_aux_gnt_after", 32'(aux_gnt), 1);
        check("fx_mem_addr_after", 32'(mem_addr), 32'h0001);
        check("fx_mem_wdata_after", 32'(mem_wdata), 32'hAAAA);
`endif

        // Locked burst: CPU joins on aux's 2nd grant, wins on cycle 5
        idle();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive(i > 0, 0, 15'h0020, '0, 1, 1, 1, 15'(i), 16'h00A0 + 16'(i));
            #1;
            check($sformatf("lk_aux_gnt%0d", i), 32'(aux_gnt), 32'(i < 4));
            check($sformatf("lk_cpu_gnt%0d", i), 32'(cpu_gnt), 32'(i == 4));
            check($sformatf("lk_mem_we%0d", i), 32'(mem_we), 32'(i < 4));
            if (i < 4) check($sformatf("lk_mem_addr%0d", i), 32'(mem_addr), 32'(i));
        end
        next_cycle();
        drive(0, 0, '0, '0, 1, 1, 1, 15'h0005, '0);
        mem_rdata = 16'hC0DE;
        #1;
        check("lk_regain_aux", 32'(aux_gnt), 1);
        check("lk_cpu_rvalid", 32'(cpu_rvalid), 1);
        check("lk_cpu_rdata", 32'(cpu_rdata), 32'hC0DE);

        // Locked burst with no CPU competition runs past MAX_BURST
        idle();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive(0, 0, '0, '0, 1, 1, 1, 15'h0100 + 15'(i), '0);
            #1;
            check($sformatf("sat_aux_gnt%0d", i), 32'(aux_gnt), 1);
        end
        next_cycle();
        cpu_req = 1'b1;
        #1;
        check("sat_cpu_wins", 32'(cpu_gnt), 1);
        check("sat_aux_loses", 32'(aux_gnt), 0);

        // Reset during a locked aux read
        idle();
        next_cycle();
        drive(0, 0, '0, '0, 1, 1, 1, 15'h0040, '0);
        #1;
        check("mr_aux_wr_gnt", 32'(aux_gnt), 1);
        next_cycle();
        drive(1, 0, 15'h0050, '0, 1, 1, 0, 15'h0041, '0);
        #1;
        check("mr_aux_rd_gnt", 32'(aux_gnt), 1);
        #1;
        rst = 1'b1;
        next_cycle();
        mem_rdata = 16'h7777;
        #1;
        check("mr_aux_rvalid_rst", 32'(aux_rvalid), 0);
        check("mr_aux_rdata_rst", 32'(aux_rdata), 0);
        check("mr_gnt_rst", 32'(aux_gnt | cpu_gnt), 0);
        next_cycle();
        rst = 1'b0;
        #1;
        check("mr_aux_rvalid_post", 32'(aux_rvalid), 0);
        check("mr_lock_cleared_cpu", 32'(cpu_gnt), 1);
        check("mr_lock_cleared_aux", 32'(aux_gnt), 0);

        idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
